jtopl_vib_ctrl: RTL

Vibrato (phase-modulation) sequencer for the OPL operator pipeline. Keeps the slot count and the sample-rate vibrato LFO step, vib_cnt. Computes the per-slot signed fnum offset and delivers the modulated fnum to the phase generator with a one-enable latency. vib_cnt is guaranteed constant across all slots of one sample frame.

---
 rtl/jtopl_vib_ctrl_if.sv | 25 ++
 rtl/jtopl_vib_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/jtopl_vib_ctrl_if.sv
// Slot-side bus of the OPL vibrato sequencer: per-slot inputs from the
// operator pipeline and the modulated fnum / status returned to it.
interface jtopl_vib_ctrl_if;
    logic       cen;
    logic       zero;
    logic       test_lfo;
    logic       vib_dep;
    logic       viben_I;
    logic [9:0] fnum_I;
    logic [4:0] slot;
    logic [2:0] vib_cnt;
    logic [3:0] pm_offset;
    logic [9:0] fnum_II;
    logic       sync_err;

    modport master (
        output cen, zero, test_lfo, vib_dep, viben_I, fnum_I,
        input  slot, vib_cnt, pm_offset, fnum_II, sync_err
    );

    modport slave (
        input  cen, zero, test_lfo, vib_dep, viben_I, fnum_I,
        output slot, vib_cnt, pm_offset, fnum_II, sync_err
    );
endinterface

// File: rtl/jtopl_vib_ctrl.sv
// OPL vibrato sequencer: slot/frame tracking, vibrato LFO step and per-slot
// fnum phase-modulation offset with a one-enable registered result.
module jtopl_vib_ctrl #(
    parameter int SLOTS   = 18,
    parameter int VIB_DIV = 1024
) (
    input  logic            clk,
    input  logic            rst,
    jtopl_vib_ctrl_if.slave bus
);

    typedef enum logic {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);
    localparam logic [9:0] FRM_LAST  = 10'(VIB_DIV - 1);
    localparam logic [4:0] SLOT_AFTER_ZERO = (SLOTS > 1) ? 5'd1 : 5'd0;

    // Offset magnitude comes from the top three fnum bits, halved on odd
    // LFO steps and again in shallow mode; vib_cnt[2] selects the sign.
    function automatic logic [3:0] calc_pm(
        input logic [2:0] vc,
        input logic       en,
        input logic       dep,
        input logic [9:0] fn
    );
        logic [2:0] r;
        logic [3:0] mag;
        r   = vc[0] ? {1'b0, fn[9:8]} : fn[9:7];
        r   = dep ? r : {1'b0, r[2:1]};
        mag = {1'b0, r};
        if (!en || (vc[1:0] == 2'd0)) begin
            calc_pm = 4'd0;
        end else if (vc[2]) begin
            calc_pm = 4'd0 - mag;
        end else begin
            calc_pm = mag;
        end
    endfunction

    state_e     state_q, state_d;
    logic [4:0] slot_q, slot_d;
    logic [9:0] frm_cnt_q, frm_cnt_d;
    logic [2:0] vib_cnt_q, vib_cnt_d;
    logic [9:0] fnum_q, fnum_d;
    logic       sync_err_q, sync_err_d;
    logic [3:0] pm_s;

    assign pm_s          = calc_pm(vib_cnt_q, bus.viben_I, bus.vib_dep, bus.fnum_I);
    assign bus.pm_offset = pm_s;
    assign bus.slot      = bus.zero ? 5'd0 : slot_q;
    assign bus.vib_cnt   = vib_cnt_q;
    assign bus.fnum_II   = fnum_q;
    assign bus.sync_err  = sync_err_q;

    // Next-state logic: alignment FSM, counters, LFO step and modulated fnum.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        frm_cnt_d  = frm_cnt_q;
        vib_cnt_d  = vib_cnt_q;
        fnum_d     = fnum_q;
        sync_err_d = sync_err_q;
        if (bus.cen) begin
            fnum_d = bus.fnum_I + {{6{pm_s[3]}}, pm_s};
            if (bus.zero) begin
                slot_d    = SLOT_AFTER_ZERO;
                state_d   = ST_RUN;
                frm_cnt_d = (frm_cnt_q == FRM_LAST) ? 10'd0 : frm_cnt_q + 10'd1;
                if ((frm_cnt_q == FRM_LAST) || bus.test_lfo) begin
                    vib_cnt_d = vib_cnt_q + 3'd1;
                end else begin
                    vib_cnt_d = vib_cnt_q;
                end
            end else begin
                slot_d = (slot_q == SLOT_LAST) ? 5'd0 : slot_q + 5'd1;
            end
            // A zero off slot 0, or slot 0 passing without a zero, is misalignment.
            case (state_q)
                ST_ALIGN: sync_err_d = sync_err_q;
                ST_RUN: begin
                    if ((bus.zero && (slot_q != 5'd0)) || (!bus.zero && (slot_q == 5'd0))) begin
                        sync_err_d = 1'b1;
                    end else begin
                        sync_err_d = sync_err_q;
                    end
                end
                default: sync_err_d = sync_err_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers with asynchronous clear back to the alignment state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ALIGN;
            slot_q     <= 5'd0;
            frm_cnt_q  <= 10'd0;
            vib_cnt_q  <= 3'd0;
            fnum_q     <= 10'd0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            frm_cnt_q  <= frm_cnt_d;
            vib_cnt_q  <= vib_cnt_d;
            fnum_q     <= fnum_d;
            sync_err_q <= sync_err_d;
        end
    end

endmodule
